// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MIPS MEM stage with data RAM, MMIO window and the MEM/WB register.
// The timer block (TH/TL/TCON/SYSTICK) is built only when MMIO_TIMER_EN is defined.
module mem_wb_stage #(
    parameter int          ADDR_W       = 8,
    parameter logic [31:0] TIMER_RST_TH = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] EX_MEM_PC_Plus4,
    input  logic [31:0] EX_MEM_ALUOut,
    input  logic [31:0] EX_MEM_rt_data,
    input  logic [4:0]  EX_MEM_rd,
    input  logic [1:0]  EX_MEM_MemtoReg,
    input  logic        EX_MEM_MemWrite,
    input  logic        EX_MEM_MemRead,
    input  logic        EX_MEM_RegWrite,
    output logic [31:0] MEM_fwd_data,
    output logic [31:0] MEM_WB_WriteData,
    output logic [4:0]  MEM_WB_rd,
    output logic        MEM_WB_RegWrite,
    output logic [7:0]  led,
    output logic        irq
);
    localparam logic [27:0] OFF_LED = 28'h3;

    logic [31:0]       ram_q [2**ADDR_W];
    logic              is_mmio;
    logic [27:0]       mmio_off;
    logic [ADDR_W-1:0] ram_idx;
    logic              ram_we;
    logic              mmio_we;
    logic [31:0]       timer_rdata;
    logic [31:0]       mmio_rdata;
    logic [31:0]       load_data;
    logic [31:0]       wb_data_d;
    logic [31:0]       wb_data_q;
    logic [4:0]        rd_q;
    logic              regwrite_q;
    logic [7:0]        led_d;
    logic [7:0]        led_q;

    // Offset compare uses all of [29:2], so the MMIO registers do not alias.
    assign is_mmio  = (EX_MEM_ALUOut[31:30] == 2'b01);
    assign mmio_off = EX_MEM_ALUOut[29:2];
    assign ram_idx  = EX_MEM_ALUOut[ADDR_W+1:2];
    assign ram_we   = EX_MEM_MemWrite & ~is_mmio;
    assign mmio_we  = EX_MEM_MemWrite & is_mmio;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= EX_MEM_rt_data;
        end
    end

`ifdef MMIO_TIMER_EN
    localparam logic [27:0] OFF_TH      = 28'h0;
    localparam logic [27:0] OFF_TL      = 28'h1;
    localparam logic [27:0] OFF_TCON    = 28'h2;
    localparam logic [27:0] OFF_SYSTICK = 28'h5;

    logic [31:0] th_q, th_d, tl_q, tl_d, systick_q, systick_d;
    logic [2:0]  tcon_q, tcon_d;
    logic        ovf;
    logic        set_status;

    always_comb begin
        th_d       = th_q;
        tl_d       = tl_q;
        tcon_d     = tcon_q;
        systick_d  = systick_q + 32'd1;
        ovf        = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
        set_status = ovf && tcon_q[1];
        if (tcon_q[0]) begin
            tl_d = ovf ? th_q : tl_q + 32'd1;
        end
        if (set_status) begin
            tcon_d[2] = 1'b1;
        end
        // Software writes override the counter, but never drop a pending status.
        if (mmio_we) begin
            case (mmio_off)
                OFF_TH:   th_d   = EX_MEM_rt_data;
                OFF_TL:   tl_d   = EX_MEM_rt_data;
                OFF_TCON: tcon_d = EX_MEM_rt_data[2:0] | {set_status, 2'b00};
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q      <= TIMER_RST_TH;
            tl_q      <= 32'h0;
            tcon_q    <= 3'b0;
            systick_q <= 32'h0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            systick_q <= systick_d;
        end
    end

    always_comb begin
        case (mmio_off)
            OFF_TH:      timer_rdata = th_q;
            OFF_TL:      timer_rdata = tl_q;
            OFF_TCON:    timer_rdata = {29'b0, tcon_q};
            OFF_SYSTICK: timer_rdata = systick_q;
            default:     timer_rdata = 32'h0;
        endcase
    end

    assign irq = tcon_q[1] & tcon_q[2];
`else
    logic unused_timer_th;

    assign unused_timer_th = ^TIMER_RST_TH;
    assign timer_rdata     = 32'h0;
    assign irq             = 1'b0;
`endif

    always_comb begin
        mmio_rdata = timer_rdata;
        if (mmio_off == OFF_LED) begin
            mmio_rdata = {24'b0, led_q};
        end
    end

    always_comb begin
        led_d = led_q;
        if (mmio_we && (mmio_off == OFF_LED)) begin
            led_d = EX_MEM_rt_data[7:0];
        end
    end

    // Asynchronous RAM read gives the pre-write word when read and write coincide.
    always_comb begin
        load_data = 32'h0;
        if (EX_MEM_MemRead) begin
            load_data = is_mmio ? mmio_rdata : ram_q[ram_idx];
        end
    end

    always_comb begin
        case (EX_MEM_MemtoReg)
            2'd1:    wb_data_d = load_data;
            2'd2:    wb_data_d = EX_MEM_PC_Plus4;
            default: wb_data_d = EX_MEM_ALUOut;
        endcase
    end

    assign MEM_fwd_data = (EX_MEM_MemtoReg == 2'd2) ? EX_MEM_PC_Plus4 : EX_MEM_ALUOut;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_data_q  <= 32'h0;
            rd_q       <= 5'h0;
            regwrite_q <= 1'b0;
            led_q      <= 8'h0;
        end else begin
            wb_data_q  <= wb_data_d;
            rd_q       <= EX_MEM_rd;
            regwrite_q <= EX_MEM_RegWrite;
            led_q      <= led_d;
        end
    end

    assign MEM_WB_WriteData = wb_data_q;
    assign MEM_WB_rd        = rd_q;
    assign MEM_WB_RegWrite  = regwrite_q;
    assign led              = led_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage (vector table plus scoreboard).
module tb_mem_wb_stage;
    localparam int ADDR_W = 8;
`ifdef MMIO_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc4, alu, rt;
    logic [4:0]  rd;
    logic [1:0]  mtr;
    logic        mw, mr, rw;
    logic [31:0] fwd, wd;
    logic [4:0]  wb_rd;
    logic        wb_rw;
    logic [7:0]  led;
    logic        irq;

    always #5 clk = ~clk;

    mem_wb_stage #(.ADDR_W(ADDR_W), .TIMER_RST_TH(32'h0)) dut (
        .clk(clk), .reset(reset),
        .EX_MEM_PC_Plus4(pc4), .EX_MEM_ALUOut(alu), .EX_MEM_rt_data(rt),
        .EX_MEM_rd(rd), .EX_MEM_MemtoReg(mtr), .EX_MEM_MemWrite(mw),
        .EX_MEM_MemRead(mr), .EX_MEM_RegWrite(rw),
        .MEM_fwd_data(fwd), .MEM_WB_WriteData(wd), .MEM_WB_rd(wb_rd),
        .MEM_WB_RegWrite(wb_rw), .led(led), .irq(irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rw;
    } wb_t;
    wb_t sb[$];

    typedef struct {
        string       name;
        logic [31:0] pc4, alu, rt;
        logic [4:0]  rd;
        logic [1:0]  mtr;
        logic        mw, mr, rw;
        logic [31:0] exp_wd, exp_fwd;
        logic [7:0]  exp_led;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [31:0] p, a, r, input logic [4:0] d,
                       input logic [1:0] m, input logic w, rdn, rgw,
                       input logic [31:0] ewd, efwd, input logic [7:0] eled);
        vec_t v;
        v.name = name; v.pc4 = p; v.alu = a; v.rt = r; v.rd = d; v.mtr = m;
        v.mw = w; v.mr = rdn; v.rw = rgw; v.exp_wd = ewd; v.exp_fwd = efwd; v.exp_led = eled;
        vecs.push_back(v);
    endtask

    // One MEM cycle: drive at negedge, check forwarding, then check the registered result.
    task automatic step(input string name, input logic [31:0] p, a, r, input logic [4:0] d,
                        input logic [1:0] m, input logic w, rdn, rgw,
                        input logic [31:0] ewd, efwd);
        wb_t e, got;
        @(negedge clk);
        pc4 = p; alu = a; rt = r; rd = d; mtr = m; mw = w; mr = rdn; rw = rgw;
        e.wd = ewd; e.rd = d; e.rw = rgw;
        sb.push_back(e);
        #1;
        chk({name, ".fwd"}, fwd, efwd);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({name, ".wd"}, wd, got.wd);
        chk({name, ".rd"}, {27'b0, wb_rd}, {27'b0, got.rd});
        chk({name, ".rw"}, {31'b0, wb_rw}, {31'b0, got.rw});
    endtask

    task automatic bubble(input string name);
        step(name, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        pc4 = '0; alu = '0; rt = '0; rd = '0; mtr = '0; mw = 0; mr = 0; rw = 0;

        add("st_dead",  32'h4, 32'h10, 32'hDEADBEEF, 5'd0, 2'd0, 1, 0, 0, 32'h10, 32'h10, 8'h00);
        add("ld_dead",  32'h8, 32'h10, 32'h0, 5'd5, 2'd1, 0, 1, 1, 32'hDEADBEEF, 32'h10, 8'h00);
        add("ld_alias", 32'h8, 32'h413, 32'h0, 5'd6, 2'd1, 0, 1, 1, 32'hDEADBEEF, 32'h413, 8'h00);
        add("ld_hi",    32'h8, 32'h8000_0010, 32'h0, 5'd6, 2'd1, 0, 1, 1, 32'hDEADBEEF, 32'h8000_0010, 8'h00);
        add("jal",      32'h0040_0008, 32'h55, 32'h0, 5'd31, 2'd2, 0, 0, 1, 32'h0040_0008, 32'h0040_0008, 8'h00);
        add("mtr3",     32'h4, 32'h1234, 32'h0, 5'd7, 2'd3, 0, 0, 1, 32'h1234, 32'h1234, 8'h00);
        add("ld_nomr",  32'h4, 32'h10, 32'h0, 5'd8, 2'd1, 0, 0, 1, 32'h0, 32'h10, 8'h00);
        add("st_20",    32'h4, 32'h20, 32'h1111_1111, 5'd0, 2'd0, 1, 0, 0, 32'h20, 32'h20, 8'h00);
        add("rmw_20",   32'h4, 32'h20, 32'h2222_2222, 5'd9, 2'd1, 1, 1, 1, 32'h1111_1111, 32'h20, 8'h00);
        add("ld_20",    32'h4, 32'h20, 32'h0, 5'd9, 2'd1, 0, 1, 1, 32'h2222_2222, 32'h20, 8'h00);
        add("st_top",   32'h4, 32'h3FC, 32'hCAFE_F00D, 5'd0, 2'd0, 1, 0, 0, 32'h3FC, 32'h3FC, 8'h00);
        add("ld_top",   32'h4, 32'h3FC, 32'h0, 5'd3, 2'd1, 0, 1, 1, 32'hCAFE_F00D, 32'h3FC, 8'h00);
        add("st_led",   32'h4, 32'h4000_000C, 32'h1A5, 5'd0, 2'd0, 1, 0, 0, 32'h4000_000C, 32'h4000_000C, 8'hA5);
        add("ld_led",   32'h4, 32'h4000_000C, 32'h0, 5'd4, 2'd1, 0, 1, 1, 32'hA5, 32'h4000_000C, 8'hA5);
        add("st_gap",   32'h4, 32'h4000_0010, 32'hFFFF_FFFF, 5'd0, 2'd0, 1, 0, 0, 32'h4000_0010, 32'h4000_0010, 8'hA5);
        add("ld_gap",   32'h4, 32'h4000_0010, 32'h0, 5'd4, 2'd1, 0, 1, 1, 32'h0, 32'h4000_0010, 8'hA5);
        add("ld_far",   32'h4, 32'h4000_0100, 32'h0, 5'd4, 2'd1, 0, 1, 1, 32'h0, 32'h4000_0100, 8'hA5);
        add("ld_keep",  32'h4, 32'h10, 32'h0, 5'd2, 2'd1, 0, 1, 1, 32'hDEADBEEF, 32'h10, 8'hA5);
        add("bubble",   32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 0, 0, 0, 32'h0, 32'h0, 8'hA5);

        repeat (3) @(posedge clk);
        #1;
        chk("rst.wd", wd, 32'h0);
        chk("rst.rd", {27'b0, wb_rd}, 32'h0);
        chk("rst.rw", {31'b0, wb_rw}, 32'h0);
        chk("rst.led", {24'b0, led}, 32'h0);
        chk("rst.irq", {31'b0, irq}, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        // One edge passes before this load is sampled, so SYSTICK reads 1.
        step("systick", 32'h4, 32'h4000_0014, 32'h0, 5'd1, 2'd1, 0, 1, 1,
             TIMER ? 32'h1 : 32'h0, 32'h4000_0014);

        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].pc4, vecs[i].alu, vecs[i].rt, vecs[i].rd, vecs[i].mtr,
                 vecs[i].mw, vecs[i].mr, vecs[i].rw, vecs[i].exp_wd, vecs[i].exp_fwd);
            chk({vecs[i].name, ".led"}, {24'b0, led}, {24'b0, vecs[i].exp_led});
            chk({vecs[i].name, ".irq"}, {31'b0, irq}, 32'h0);
        end

        step("pre_rst", 32'h4, 32'h1234, 32'h0, 5'd7, 2'd3, 0, 0, 1, 32'h1234, 32'h1234);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst.wd", wd, 32'h0);
        chk("midrst.rw", {31'b0, wb_rw}, 32'h0);
        chk("midrst.led", {24'b0, led}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step("ram_kept", 32'h4, 32'h10, 32'h0, 5'd5, 2'd1, 0, 1, 1, 32'hDEADBEEF, 32'h10);

        step("st_th", 32'h4, 32'h4000_0000, 32'hFFFF_FFFE, 5'd0, 2'd0, 1, 0, 0, 32'h4000_0000, 32'h4000_0000);
        step("st_tl", 32'h4, 32'h4000_0004, 32'hFFFF_FFFE, 5'd0, 2'd0, 1, 0, 0, 32'h4000_0004, 32'h4000_0004);
        step("st_tcon", 32'h4, 32'h4000_0008, 32'h3, 5'd0, 2'd0, 1, 0, 0, 32'h4000_0008, 32'h4000_0008);
        chk("tmr.irq0", {31'b0, irq}, 32'h0);
        bubble("tmr.b1");
        chk("tmr.irq1", {31'b0, irq}, 32'h0);
        bubble("tmr.b2");
        chk("tmr.irq_ovf", {31'b0, irq}, {31'b0, TIMER});
        step("ld_tl", 32'h4, 32'h4000_0004, 32'h0, 5'd10, 2'd1, 0, 1, 1,
             TIMER ? 32'hFFFF_FFFE : 32'h0, 32'h4000_0004);
        chk("tmr.irq_hold", {31'b0, irq}, {31'b0, TIMER});
        step("tcon_ovf", 32'h4, 32'h4000_0008, 32'h3, 5'd0, 2'd0, 1, 0, 0, 32'h4000_0008, 32'h4000_0008);
        chk("tmr.irq_kept", {31'b0, irq}, {31'b0, TIMER});
        step("tcon_clr", 32'h4, 32'h4000_0008, 32'h3, 5'd0, 2'd0, 1, 0, 0, 32'h4000_0008, 32'h4000_0008);
        chk("tmr.irq_clr", {31'b0, irq}, 32'h0);
        step("ld_tcon", 32'h4, 32'h4000_0008, 32'h0, 5'd11, 2'd1, 0, 1, 1,
             TIMER ? 32'h3 : 32'h0, 32'h4000_0008);
        chk("tmr.irq_again", {31'b0, irq}, {31'b0, TIMER});
        step("ld_th", 32'h4, 32'h4000_0000, 32'h0, 5'd12, 2'd1, 0, 1, 1,
             TIMER ? 32'hFFFF_FFFE : 32'h0, 32'h4000_0000);
        bubble("tail");

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register of the five-stage MIPS pipeline. It consumes the EX/MEM register outputs, performs the load or store against an internal word-addressed data RAM or a small MMIO window, and selects the write-back value. It registers the result into the MEM/WB boundary and provides a combinational forwarding value back to the hazard unit.

## Interface
- `ADDR_W`, 8: RAM word-address width; RAM depth is 2^ADDR_W words.
- `TIMER_RST_TH`, 32'h0: reset value of the timer reload register TH.
- `clk` in 1: rising-edge clock.
- `reset` in 1: reset. Asynchronous, active-low; clears every register while low.
- `EX_MEM_PC_Plus4` in 32: PC+4 of the instruction in MEM.
- `EX_MEM_ALUOut` in 32: effective address, or ALU result.
- `EX_MEM_rt_data` in 32: store data.
- `EX_MEM_rd` in 5: destination register.
- `EX_MEM_MemtoReg` in 2: write-back select. 0=ALUOut, 1=load data, 2=PC+4, 3=ALUOut.
- `EX_MEM_MemWrite`, `EX_MEM_MemRead`, `EX_MEM_RegWrite` in 1 each: control signals.
- `MEM_fwd_data` out 32: combinational forwarding value. PC+4 when MemtoReg==2, else ALUOut.
- `MEM_WB_WriteData` out 32: registered write-back value.
- `MEM_WB_rd` out 5: registered destination register.
- `MEM_WB_RegWrite` out 1: registered write enable.
- `led` out 8: LED register.
- `irq` out 1: timer interrupt request.

## Operation
- Address decode on `EX_MEM_ALUOut`:
  - Bits [31:30]==2'b01 select MMIO.
  - All other addresses select RAM at word index ALUOut[ADDR_W+1:2]. Upper bits are ignored, so the RAM aliases across the space.
  - Bits [1:0] are ignored everywhere; all accesses are whole words.
- RAM:
  - Asynchronous read.
  - Synchronous write on the rising edge when MemWrite=1.
  - Not cleared by reset.
- MMIO map (byte offsets from 0x4000_0000):
  - 0x00 TH: reload value.
  - 0x04 TL: counter.
  - 0x08 TCON: bit0 enable, bit1 irq enable, bit2 irq status. Bits [31:3] read as 0.
  - 0x0C LED: bits [7:0] only.
  - 0x14 SYSTICK: read-only.
  - Any other offset reads 0 and ignores writes.
- Timer, each cycle with TCON[0]=1:
  - If TL==32'hFFFF_FFFF: TL <= TH, and if TCON[1]=1 then TCON[2] <= 1.
  - Otherwise TL <= TL+1.
- SYSTICK increments by 1 every cycle and wraps modulo 2^32.
- `irq` = TCON[1] & TCON[2]. It is combinational from registers, so no extra latency.
- Load data = RAM word or MMIO word when MemRead=1, else 0.
- `MEM_WB_WriteData` is selected per MemtoReg and registered.
- Simultaneous events:
  - A software write to TH or TL in the same cycle as a counter update: the software write wins.
  - A software write to TCON in the same cycle as an overflow that sets status: written bits [1:0] are applied and TCON[2] ends at 1, so no interrupt is lost.
  - MemRead and MemWrite both 1: the write is performed, and the read returns the pre-write value.

## Timing
- Store: takes effect at the rising edge ending the instruction's MEM cycle. A load in the next cycle to the same address returns the new value.
- Load: result appears on `MEM_WB_WriteData` one cycle after the instruction is presented on the EX_MEM_* inputs.
- `MEM_fwd_data` has zero latency.
- Reset values of outputs and registers:
  - MEM_WB_WriteData=0, MEM_WB_rd=0, MEM_WB_RegWrite=0.
  - led=0, irq=0.
  - TH=TIMER_RST_TH, TL=0, TCON=0, SYSTICK=0.
- Reset asserted mid-operation: all registers clear immediately. Any store coinciding with reset assertion is not guaranteed.
- A bubble (all control inputs 0) produces MEM_WB_RegWrite=0 on the next edge and performs no memory side effect.

## Configuration
- `MMIO_TIMER_EN` defined:
  - TH, TL, TCON and SYSTICK are implemented as described.
- `MMIO_TIMER_EN` undefined:
  - Those four registers are removed.
  - Their offsets read 0 and ignore writes.
  - `irq` is tied 0.
  - The LED register and the RAM are unaffected.

## Test plan
- Reset low, then release: all outputs 0. A load from 0x4000_0014 in the first cycle after release returns a small nonzero count.
- Store 32'hDEADBEEF to 0x10, then load 0x10 with MemtoReg=1, rd=5, RegWrite=1 on the next cycle -> the cycle after, MEM_WB_WriteData=32'hDEADBEEF, MEM_WB_rd=5, MEM_WB_RegWrite=1.
- MemtoReg=2 with PC_Plus4=32'h0040_0008 -> MEM_fwd_data=32'h0040_0008 in the same cycle; MEM_WB_WriteData=32'h0040_0008 after the edge.
- Write TH=32'hFFFF_FFFE, TL=32'hFFFF_FFFE, then TCON=3 -> TL overflows after 2 cycles and reloads 32'hFFFF_FFFE; irq=1 from then on. Writing TCON=3 clears irq, except when an overflow falls in the same cycle, where irq stays 1.
- Store 32'h1A5 to 0x4000_000C -> led=8'hA5; a load from 0x4000_0010 returns 0.
- With `MMIO_TIMER_EN` undefined, repeat the timer scenario -> loads from the timer offsets return 0 and irq stays 0.
